// File: rtl/t81_stack_engine.sv
// t81_stack_engine: parametrised opcode-driven operand stack.
// One opcode is accepted per valid/ready handshake in IDLE and executed in
// the following EXEC cycle, producing a one-cycle result_valid pulse.
// Sticky error flags report overflow, underflow and illegal opcodes.
// Optional feature macro: T81_MUL_EN enables opcode 0x07 MUL.
module t81_stack_engine #(
  parameter  int WIDTH = 81,
  parameter  int DEPTH = 8,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] operand,
  input  logic             clear_err,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [DW-1:0]    depth,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             err_illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_PUSH = 8'h01;
  localparam logic [7:0] OP_POP  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_DUP  = 8'h05;
  localparam logic [7:0] OP_SWAP = 8'h06;
`ifdef T81_MUL_EN
  localparam logic [7:0] OP_MUL  = 8'h07;
`endif

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                 state, state_nx;
  logic [7:0]             op_p0;
  logic [WIDTH-1:0]       arg_p0;
  logic [WIDTH-1:0]       stack [DEPTH];
  logic [AW-1:0]          t_idx, n_idx, p_idx;
  logic [WIDTH-1:0]       t_val, n_val, res_val;
  logic                   ovf, unf, ill;

  // Top, next-below-top and push slot derived from the current depth
  assign t_idx    = AW'(depth - DW'(1));
  assign n_idx    = AW'(depth - DW'(2));
  assign p_idx    = AW'(depth);
  assign t_val    = stack[t_idx];
  assign n_val    = stack[n_idx];
  assign op_ready = (state == IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: accept in IDLE, always return from EXEC after one cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (op_valid) state_nx = EXEC;
      EXEC:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Accept stage: capture opcode and operand on the handshake
  always_ff @(posedge clk) begin
    if (op_valid && op_ready) begin
      op_p0  <= opcode;
      arg_p0 <= operand;
    end
  end

  // Opcode decode: error conditions and result value for the latched op
  always_comb begin
    ovf     = 1'b0;
    unf     = 1'b0;
    ill     = 1'b0;
    res_val = result;
    case (op_p0)
      OP_NOP:  res_val = (depth == '0) ? '0 : t_val;
      OP_PUSH: begin ovf = (depth == DW'(DEPTH)); res_val = arg_p0; end
      OP_POP:  begin unf = (depth == '0);         res_val = t_val;  end
      OP_ADD:  begin unf = (depth < DW'(2));      res_val = n_val + t_val; end
      OP_SUB:  begin unf = (depth < DW'(2));      res_val = n_val - t_val; end
      OP_DUP:  begin
        unf     = (depth == '0);
        ovf     = (depth == DW'(DEPTH));
        res_val = t_val;
      end
      OP_SWAP: begin unf = (depth < DW'(2));      res_val = n_val;  end
`ifdef T81_MUL_EN
      OP_MUL:  begin unf = (depth < DW'(2));      res_val = n_val * t_val; end
`endif
      default: ill = 1'b1;
    endcase
  end

  // Execute stage: update stack, depth, result, pulse and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
      depth         <= '0;
      result        <= '0;
      result_valid  <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_illegal   <= 1'b0;
    end else begin
      result_valid <= (state == EXEC);
      if (clear_err) begin
        err_overflow  <= 1'b0;
        err_underflow <= 1'b0;
        err_illegal   <= 1'b0;
      end
      if (state == EXEC) begin
        if (ovf) err_overflow  <= 1'b1;
        if (unf) err_underflow <= 1'b1;
        if (ill) err_illegal   <= 1'b1;
        if (!(ovf || unf || ill)) begin
          result <= res_val;
          case (op_p0)
            OP_PUSH: begin stack[p_idx] <= arg_p0; depth <= depth + DW'(1); end
            OP_DUP:  begin stack[p_idx] <= t_val;  depth <= depth + DW'(1); end
            OP_POP:  depth <= depth - DW'(1);
            OP_SWAP: begin stack[n_idx] <= t_val; stack[t_idx] <= n_val; end
            OP_ADD, OP_SUB
`ifdef T81_MUL_EN
            , OP_MUL
`endif
            : begin stack[n_idx] <= res_val; depth <= depth - DW'(1); end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
